// File: rtl/muskbus_arbiter.sv
// muskbus_arbiter
// Shares the single Muskbus port between N_REQ requesters. Port 0 is the
// instruction-fetch cache and port 1 is the data cache. One whole transaction
// runs at a time: request beats first, then response beats for reads.
// Requesters are granted round-robin. Responses go back to the owner of the
// outstanding transaction.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   m_reqcyc/m_req/m_reqtag        per-requester request valid, beat, tag
//                                  (tag bit 12: 1=read, 0=write)
//   m_reqack                       per-requester request beat accepted
//   m_respcyc                      per-requester response beat valid
//   m_resp/m_resptag               response data and tag, broadcast
//   m_respack                      per-requester response beat accepted
//   bus_reqcyc/bus_req/bus_reqtag  request side toward the top-level bus
//   bus_reqack                     bus accepted the request beat
//   bus_respcyc/bus_resp/bus_resptag  response side from the bus
//   bus_respack                    response beat accepted by the owner
//   grant                          one-hot current owner, 0 when idle
//   err                            sticky response timeout flag

module muskbus_arbiter #(
    parameter int N_REQ   = 2,
    parameter int BEATS   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    m_reqcyc,
    input  logic [N_REQ*64-1:0] m_req,
    input  logic [N_REQ*13-1:0] m_reqtag,
    output logic [N_REQ-1:0]    m_reqack,
    output logic [N_REQ-1:0]    m_respcyc,
    output logic [63:0]         m_resp,
    output logic [12:0]         m_resptag,
    input  logic [N_REQ-1:0]    m_respack,
    output logic                bus_reqcyc,
    output logic [63:0]         bus_req,
    output logic [12:0]         bus_reqtag,
    input  logic                bus_reqack,
    input  logic                bus_respcyc,
    input  logic [63:0]         bus_resp,
    input  logic [12:0]         bus_resptag,
    output logic                bus_respack,
    output logic [N_REQ-1:0]    grant,
    output logic                err
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BEAT_W = $clog2(BEATS + 2);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [N_REQ-1:0]   grant_nx;
    logic [IDX_W-1:0]   owner, owner_nx;
    logic [IDX_W-1:0]   rr_ptr, rr_nx;
    logic [IDX_W-1:0]   next_ptr;
    logic [BEAT_W-1:0]  beat_cnt, beat_nx;
    logic [WAIT_W-1:0]  wait_cnt, wait_nx;
    logic               is_read, is_read_nx;
    logic               err_nx;

    logic               found;
    logic [IDX_W-1:0]   winner;
    int                 arb_cand;

    logic               req_fire;
    logic               resp_fire;

    // Round-robin search: the first requester at or above rr_ptr wins,
    // wrapping around to port 0.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        arb_cand = 0;
        for (int i = 0; i < N_REQ; i++) begin
            arb_cand = (int'(rr_ptr) + i) % N_REQ;
            if (!found && m_reqcyc[arb_cand]) begin
                found  = 1'b1;
                winner = IDX_W'(arb_cand);
            end
        end
    end

    // The pointer moves past the owner once its transaction is retired, so
    // that owner has lowest priority in the next arbitration round.
    always_comb begin
        if (int'(owner) == N_REQ - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = owner + 1'b1;
        end
    end

    // Routing of the bus to the owner. Outside REQ and RESP everything is
    // held at zero, so bus responses that arrive while idle or requesting
    // never reach a cache.
    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        m_reqack    = '0;
        m_respcyc   = '0;
        m_resp      = '0;
        m_resptag   = '0;
        bus_respack = 1'b0;
        if (state == REQ) begin
            bus_reqcyc      = m_reqcyc[owner];
            bus_req         = m_req[int'(owner)*64 +: 64];
            bus_reqtag      = m_reqtag[int'(owner)*13 +: 13];
            m_reqack[owner] = bus_reqack;
        end
        if (state == RESP) begin
            m_respcyc[owner] = bus_respcyc;
            m_resp           = bus_resp;
            m_resptag        = bus_resptag;
            bus_respack      = m_respack[owner];
        end
    end

    assign req_fire  = bus_reqcyc && bus_reqack;
    assign resp_fire = bus_respcyc && bus_respack;

    // Next-state logic. Reads leave REQ after the address beat; writes after
    // the address plus BEATS data beats. A requester that withdraws before
    // its first beat is accepted loses the grant without advancing rr_ptr.
    // Once a beat has been accepted, a withdrawn request just stalls in REQ.
    always_comb begin
        state_nx   = state;
        grant_nx   = grant;
        owner_nx   = owner;
        rr_nx      = rr_ptr;
        beat_nx    = beat_cnt;
        wait_nx    = wait_cnt;
        is_read_nx = is_read;
        err_nx     = err;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx         = REQ;
                    owner_nx         = winner;
                    grant_nx         = '0;
                    grant_nx[winner] = 1'b1;
                    beat_nx          = '0;
                    is_read_nx       = m_reqtag[int'(winner)*13 + 12];
                end
            end
            REQ: begin
                if (req_fire) begin
                    if (is_read) begin
                        state_nx = RESP;
                        beat_nx  = '0;
                        wait_nx  = '0;
                    end else if (beat_cnt == BEAT_W'(BEATS)) begin
                        state_nx = IDLE;
                        grant_nx = '0;
                        rr_nx    = next_ptr;
                    end else begin
                        beat_nx = beat_cnt + 1'b1;
                    end
                end else if (!m_reqcyc[owner] && beat_cnt == '0) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                end
            end
            RESP: begin
                if (resp_fire) begin
                    wait_nx = '0;
                    if (beat_cnt == BEAT_W'(BEATS - 1)) begin
                        state_nx = IDLE;
                        grant_nx = '0;
                        rr_nx    = next_ptr;
                    end else begin
                        beat_nx = beat_cnt + 1'b1;
                    end
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    // The bus stopped answering. Drop the transaction and
                    // flag it; the owner is treated as served for fairness.
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                    grant_nx = '0;
                    rr_nx    = next_ptr;
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    // State register. Reset drops any in-flight transaction immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            wait_cnt <= '0;
            is_read  <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_nx;
            beat_cnt <= beat_nx;
            wait_cnt <= wait_nx;
            is_read  <= is_read_nx;
            err      <= err_nx;
        end
    end

endmodule

// File: tb/tb_muskbus_arbiter.sv
// tb_muskbus_arbiter
// Self-checking bench for muskbus_arbiter with N_REQ=2, BEATS=8, TIMEOUT=16.
// A per-cycle vector table covers arbitration, a full write, abort and
// ignored responses. Hand-written sequences cover reads with backpressure,
// contention, timeout and asynchronous reset. Expected response data is
// queued when the bus drives a beat and popped when the owner accepts it.

module tb_muskbus_arbiter;

    localparam int N_REQ   = 2;
    localparam int BEATS   = 8;
    localparam int TIMEOUT = 16;

    logic                clk;
    logic                reset;
    logic [N_REQ-1:0]    m_reqcyc;
    logic [N_REQ*64-1:0] m_req;
    logic [N_REQ*13-1:0] m_reqtag;
    logic [N_REQ-1:0]    m_reqack;
    logic [N_REQ-1:0]    m_respcyc;
    logic [63:0]         m_resp;
    logic [12:0]         m_resptag;
    logic [N_REQ-1:0]    m_respack;
    logic                bus_reqcyc;
    logic [63:0]         bus_req;
    logic [12:0]         bus_reqtag;
    logic                bus_reqack;
    logic                bus_respcyc;
    logic [63:0]         bus_resp;
    logic [12:0]         bus_resptag;
    logic                bus_respack;
    logic [N_REQ-1:0]    grant;
    logic                err;

    int errors = 0;
    int checks = 0;

    logic [63:0] sb[$];

    typedef struct {
        logic [1:0] reqcyc;
        logic [1:0] rd;
        logic       ack;
        logic       respcyc;
        logic [1:0] respack;
        logic [1:0] exp_grant;
        logic [1:0] exp_reqack;
        logic       exp_bus_reqcyc;
        int         exp_src;
    } vec_t;

    vec_t vecs[18];

    muskbus_arbiter #(
        .N_REQ  (N_REQ),
        .BEATS  (BEATS),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m_reqcyc   (m_reqcyc),
        .m_req      (m_req),
        .m_reqtag   (m_reqtag),
        .m_reqack   (m_reqack),
        .m_respcyc  (m_respcyc),
        .m_resp     (m_resp),
        .m_resptag  (m_resptag),
        .m_respack  (m_respack),
        .bus_reqcyc (bus_reqcyc),
        .bus_req    (bus_req),
        .bus_reqtag (bus_reqtag),
        .bus_reqack (bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_resp   (bus_resp),
        .bus_resptag(bus_resptag),
        .bus_respack(bus_respack),
        .grant      (grant),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a sequence wedges despite its own bounds.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] rc, input logic [1:0] rd,
                                input logic ack, input logic rsp,
                                input logic [1:0] g, input logic [1:0] ra,
                                input logic brc, input int src);
        vec_t v;
        v.reqcyc         = rc;
        v.rd             = rd;
        v.ack            = ack;
        v.respcyc        = rsp;
        v.respack        = {rsp, rsp};
        v.exp_grant      = g;
        v.exp_reqack     = ra;
        v.exp_bus_reqcyc = brc;
        v.exp_src        = src;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        m_reqcyc    = v.reqcyc;
        m_req       = {64'h2000, 64'h1000};
        m_reqtag    = {v.rd[1], 12'h021, v.rd[0], 12'h010};
        bus_reqack  = v.ack;
        bus_respcyc = v.respcyc;
        bus_resp    = 64'hDEAD;
        bus_resptag = 13'h1ABC;
        m_respack   = v.respack;
    endtask

    task automatic check_reset_outputs();
        checkOutput("reset grant", 64'(grant), 64'd0);
        checkOutput("reset err", 64'(err), 64'd0);
        checkOutput("reset bus_reqcyc", 64'(bus_reqcyc), 64'd0);
        checkOutput("reset m_reqack", 64'(m_reqack), 64'd0);
        checkOutput("reset m_respcyc", 64'(m_respcyc), 64'd0);
        checkOutput("reset bus_respack", 64'(bus_respack), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset       = 1'b1;
        m_reqcyc    = '0;
        m_respack   = '0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        sb.delete();
        @(posedge clk);
        #4;
        check_reset_outputs();
        reset = 1'b0;
    endtask

    task automatic set_read(input int p, input logic [63:0] addr);
        m_req[p*64 +: 64]  = addr;
        m_reqtag[p*13 +: 13] = {1'b1, 12'(p + 1)};
        m_reqcyc[p]        = 1'b1;
    endtask

    // Waits (bounded) for any grant, then compares it with the expected owner.
    task automatic wait_grant(input logic [1:0] oh);
        int n;
        n = 0;
        while (grant == 2'b00 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("grant owner", 64'(grant), 64'(oh));
    endtask

    // Entered at posedge+1 with the grant held. Stalls the bus for ack_delay
    // cycles, then accepts the address beat.
    task automatic req_phase(input int p, input int ack_delay, input bit hold);
        logic [1:0]  oh;
        logic [63:0] addr;
        oh       = '0;
        oh[p]    = 1'b1;
        addr     = m_req[p*64 +: 64];
        bus_reqack = 1'b0;
        for (int k = 0; k < ack_delay; k++) begin
            #4;
            checkOutput("stall bus_req", bus_req, addr);
            checkOutput("stall m_reqack", 64'(m_reqack), 64'd0);
            @(posedge clk);
            #1;
        end
        bus_reqack = 1'b1;
        #4;
        checkOutput("ack bus_reqcyc", 64'(bus_reqcyc), 64'd1);
        checkOutput("ack m_reqack", 64'(m_reqack), 64'(oh));
        @(posedge clk);
        #1;
        bus_reqack = 1'b0;
        if (!hold) begin
            m_reqcyc[p] = 1'b0;
        end
    endtask

    // Entered at posedge+1 in RESP. Drives nbeats response beats; beat
    // stall_at is refused by the owner for stall_len cycles first.
    task automatic resp_phase(input int p, input logic [63:0] base,
                              input int stall_at, input int stall_len,
                              input int nbeats);
        logic [1:0]  oh;
        logic [63:0] exp_data;
        int          got;
        oh    = '0;
        oh[p] = 1'b1;
        got   = 0;
        for (int b = 0; b < nbeats; b++) begin
            bus_respcyc = 1'b1;
            bus_resp    = base + 64'(b);
            bus_resptag = {1'b1, 12'(b)};
            sb.push_back(base + 64'(b));
            for (int s = 0; s < ((b == stall_at) ? stall_len : 0); s++) begin
                m_respack[p] = 1'b0;
                #4;
                checkOutput("stall bus_respack", 64'(bus_respack), 64'd0);
                checkOutput("stall m_respcyc", 64'(m_respcyc), 64'(oh));
                @(posedge clk);
                #1;
            end
            m_respack[p] = 1'b1;
            #4;
            checkOutput("non-owner m_respcyc", 64'(m_respcyc & ~oh), 64'd0);
            if (m_respcyc[p] && bus_respack && sb.size() > 0) begin
                exp_data = sb.pop_front();
                checkOutput("resp data", m_resp, exp_data);
                checkOutput("resp tag", 64'(m_resptag), 64'({1'b1, 12'(b)}));
                got++;
            end else begin
                checkOutput("resp beat valid+ack", 64'({m_respcyc[p], bus_respack}), 64'd3);
            end
            @(posedge clk);
            #1;
        end
        bus_respcyc  = 1'b0;
        m_respack[p] = 1'b0;
        checkOutput("beats delivered", 64'(got), 64'(nbeats));
        if (nbeats == BEATS) begin
            #4;
            checkOutput("grant after resp", 64'(grant), 64'd0);
            checkOutput("scoreboard empty", 64'(sb.size()), 64'd0);
        end
    endtask

    initial begin
        int exp_src;
        logic [63:0] exp_req;
        logic [12:0] exp_tag;

        reset       = 1'b1;
        m_reqcyc    = '0;
        m_req       = '0;
        m_reqtag    = '0;
        m_respack   = '0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
        repeat (2) @(posedge clk);
        #4;
        check_reset_outputs();
        reset = 1'b0;

        // Per-cycle table: idle, port-1 write of 1+BEATS beats with stray bus
        // responses, port-0 abort before first ack, rr_ptr kept after abort.
        vecs[0]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, -1);
        vecs[1]  = mk(2'b10, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, -1);
        for (int i = 2; i <= 10; i++) begin
            vecs[i] = mk(2'b10, 2'b00, 1'b1, (i < 5) ? 1'b1 : 1'b0,
                         2'b10, 2'b10, 1'b1, 1);
        end
        vecs[11] = mk(2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, -1);
        vecs[12] = mk(2'b01, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, -1);
        vecs[13] = mk(2'b00, 2'b01, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 0);
        vecs[14] = mk(2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, -1);
        vecs[15] = mk(2'b11, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 0);
        vecs[16] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 0);
        vecs[17] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, -1);

        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            #4;
            exp_src = vecs[i].exp_src;
            exp_req = (exp_src == 0) ? 64'h1000 : (exp_src == 1) ? 64'h2000 : 64'h0;
            exp_tag = (exp_src == 0) ? {vecs[i].rd[0], 12'h010} :
                      (exp_src == 1) ? {vecs[i].rd[1], 12'h021} : 13'h0;
            checkOutput($sformatf("vec%0d grant", i), 64'(grant), 64'(vecs[i].exp_grant));
            checkOutput($sformatf("vec%0d m_reqack", i), 64'(m_reqack), 64'(vecs[i].exp_reqack));
            checkOutput($sformatf("vec%0d bus_reqcyc", i), 64'(bus_reqcyc), 64'(vecs[i].exp_bus_reqcyc));
            checkOutput($sformatf("vec%0d bus_req", i), bus_req, exp_req);
            checkOutput($sformatf("vec%0d bus_reqtag", i), 64'(bus_reqtag), 64'(exp_tag));
            checkOutput($sformatf("vec%0d m_respcyc", i), 64'(m_respcyc), 64'd0);
            checkOutput($sformatf("vec%0d bus_respack", i), 64'(bus_respack), 64'd0);
        end

        // Single read from reset: one-cycle arbitration, ack in cycle 2.
        do_reset();
        m_req    = '0;
        m_reqtag = '0;
        @(posedge clk);
        #1;
        set_read(0, 64'h1000);
        #4;
        checkOutput("arb cycle grant", 64'(grant), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("arb latency grant", 64'(grant), 64'd1);
        req_phase(0, 1, 1'b0);
        checkOutput("reqack single pulse", 64'(m_reqack), 64'd0);
        resp_phase(0, 64'hA0, -1, 0, BEATS);

        // Backpressure: request stalled 5 cycles, beat 3 refused 2 cycles.
        @(posedge clk);
        #1;
        set_read(0, 64'h3000);
        wait_grant(2'b01);
        req_phase(0, 5, 1'b0);
        resp_phase(0, 64'hB0, 3, 2, BEATS);

        // Contention: both ports read continuously, grants must alternate.
        do_reset();
        @(posedge clk);
        #1;
        set_read(0, 64'h4000);
        set_read(1, 64'h5000);
        for (int t = 0; t < 4; t++) begin
            wait_grant((t % 2 == 0) ? 2'b01 : 2'b10);
            req_phase(t % 2, 1, 1'b1);
            resp_phase(t % 2, 64'hC0 + 64'(t * 16), -1, 0, BEATS);
        end
        m_reqcyc = '0;

        // Timeout: port 0 read never answered.
        do_reset();
        @(posedge clk);
        #1;
        set_read(0, 64'h6000);
        wait_grant(2'b01);
        req_phase(0, 0, 1'b0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(posedge clk);
            #1;
            if (k == TIMEOUT - 1) begin
                checkOutput("err before timeout", 64'(err), 64'd0);
                checkOutput("grant before timeout", 64'(grant), 64'd1);
            end
            if (k == TIMEOUT) begin
                checkOutput("err at timeout", 64'(err), 64'd1);
                checkOutput("grant at timeout", 64'(grant), 64'd0);
            end
        end
        @(posedge clk);
        #1;
        set_read(1, 64'h7000);
        wait_grant(2'b10);
        req_phase(1, 0, 1'b0);
        resp_phase(1, 64'hD0, -1, 0, BEATS);
        checkOutput("err sticky", 64'(err), 64'd1);

        // Port 0 completes, so rr_ptr points at port 1; then reset mid-RESP
        // of a port-1 read must restart arbitration at port 0.
        @(posedge clk);
        #1;
        set_read(0, 64'h8000);
        wait_grant(2'b01);
        req_phase(0, 0, 1'b0);
        resp_phase(0, 64'hE0, -1, 0, BEATS);
        @(posedge clk);
        #1;
        set_read(1, 64'h9000);
        wait_grant(2'b10);
        req_phase(1, 0, 1'b0);
        resp_phase(1, 64'hF0, -1, 0, 4);
        bus_respcyc  = 1'b1;
        m_respack[1] = 1'b1;
        #1;
        checkOutput("pre-reset m_respcyc", 64'(m_respcyc), 64'd2);
        reset = 1'b1;
        #1;
        checkOutput("async reset grant", 64'(grant), 64'd0);
        checkOutput("async reset m_respcyc", 64'(m_respcyc), 64'd0);
        checkOutput("async reset err", 64'(err), 64'd0);
        checkOutput("async reset bus_respack", 64'(bus_respack), 64'd0);
        bus_respcyc = 1'b0;
        m_respack   = '0;
        sb.delete();
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        set_read(0, 64'hA000);
        set_read(1, 64'hB000);
        #4;
        checkOutput("post-reset arb cycle", 64'(grant), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("post-reset grant port0", 64'(grant), 64'd1);
        req_phase(0, 0, 1'b0);
        resp_phase(0, 64'h100, -1, 0, BEATS);
        wait_grant(2'b10);
        req_phase(1, 0, 1'b0);
        resp_phase(1, 64'h200, -1, 0, BEATS);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muskbus_arbiter.md
Name: muskbus_arbiter

Overview:
- Shares the single Muskbus port between N_REQ requesters: instruction-fetch cache on port 0, data cache on port 1.
- Sequences one whole transaction at a time: request beats, then, for reads, response beats.
- Grants round-robin and routes responses back to the owner of the outstanding transaction.
- Sits between the core's caches and the top-level bus.

Parameters:
N_REQ, 2, number of requester ports (1..4)
BEATS, 8, 64-bit data beats per line (read response or write data)
TIMEOUT, 1024, max cycles waiting in RESP before err is raised

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
m_reqcyc  in  N_REQ  per-requester request valid
m_req  in  N_REQ*64  per-requester request beat (addr or write data); port i at [64*i+63:64*i]
m_reqtag  in  N_REQ*13  per-requester tag; bit 12: 1=read, 0=write
m_reqack  out  N_REQ  per-requester beat accepted
m_respcyc  out  N_REQ  per-requester response beat valid
m_resp  out  64  response data, broadcast
m_resptag  out  13  response tag, broadcast
m_respack  in  N_REQ  per-requester response beat accepted
bus_reqcyc  out  1  to bus
bus_req  out  64  to bus
bus_reqtag  out  13  to bus
bus_reqack  in  1  from bus
bus_respcyc  in  1  from bus
bus_resp  in  64  from bus
bus_resptag  in  13  from bus
bus_respack  out  1  to bus
grant  out  N_REQ  one-hot current owner, 0 when IDLE
err  out  1  sticky response timeout

Behaviour:
- Reset (async, immediate): state=IDLE; grant=0; rr_ptr=0; beat_cnt=0; err=0. All outputs 0. An in-flight transaction is dropped with no completion.
- States: IDLE, REQ, RESP.
- IDLE:
  - When any m_reqcyc is set, pick the first set bit searching from rr_ptr upward with wrap.
  - Next cycle: grant registered one-hot, state=REQ, beat_cnt=0, is_read latched from the winner's m_reqtag[12].
  - Arbitration latency is exactly 1 cycle. No request means stay in IDLE.
- REQ:
  - bus_reqcyc/bus_req/bus_reqtag = granted requester's inputs, combinationally.
  - m_reqack[g] = bus_reqack; all other m_reqack bits are 0.
  - Each cycle with bus_reqcyc && bus_reqack increments beat_cnt.
  - Read: after 1 acked beat, go to RESP with beat_cnt=0.
  - Write: after 1+BEATS acked beats (address + data), go to IDLE. rr_ptr = g+1 mod N_REQ; grant=0.
  - If m_reqcyc[g] drops before the first beat is acked: abort to IDLE, rr_ptr unchanged.
  - Dropping m_reqcyc[g] after the first acked beat is a protocol error; the arbiter holds state.
- RESP:
  - m_respcyc[g] = bus_respcyc; m_resp = bus_resp; m_resptag = bus_resptag.
  - bus_respack = m_respack[g]; m_respcyc of all non-owners is 0.
  - Each cycle with bus_respcyc && bus_respack increments beat_cnt.
  - After BEATS beats: IDLE, rr_ptr = g+1, grant=0.
  - bus_respcyc while in IDLE or REQ is ignored and bus_respack=0.
- Timeout:
  - wait_cnt clears on entering RESP and on each accepted response beat, and increments otherwise.
  - When wait_cnt reaches TIMEOUT: err=1 (sticky until reset), state=IDLE, grant=0.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,N_REQ-1,0. No requester waits more than N_REQ-1 transactions.
- At most one transaction is outstanding; the next grant is issued only from IDLE. Minimum gap between transactions is 1 IDLE cycle.
- beat_cnt width is clog2(BEATS+2). Counts never wrap within legal operation.

Test Plan:
- Single read: port 0 reqcyc, req=0x1000, tag[12]=1; bus acks cycle 2 and returns 8 beats 0xA0..0xA7 → grant=01 at cycle 1. m_reqack[0] pulses once. m_respcyc[0] carries 0xA0..0xA7 in order, m_respcyc[1]=0 throughout. Back to IDLE with grant=0.
- Write: port 1 sends addr 0x2000 plus 8 data beats, bus acks every cycle → exactly 9 bus_reqack beats forwarded. No RESP state entered. grant returns to 0 after the 9th ack.
- Contention: both ports issue reads continuously for 4 transactions from reset → grant order 0,1,0,1. Each loser sees m_reqack=0 while waiting.
- Backpressure: bus_reqack held low for 5 cycles, and m_respack[0] low on beat 3 for 2 cycles → bus_req stable during the stall. The beat count is not advanced while stalled. Exactly 8 response beats are delivered.
- Timeout: TIMEOUT=16, read issued, bus never responds → err=1 exactly 16 cycles after entering RESP. grant=0 and port 1 is then granted normally while err stays 1.
- Async reset mid-RESP after beat 4 → same-cycle grant=0, m_respcyc=0, err=0. A new request after reset is granted starting with port 0.
